alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - Registered WIDTH-bit integer ALU: two operands, 2-bit opcode (add, subtract, AND, OR).
// - Outputs a registered result plus five status flags: zero, carry, sign, parity, overflow.
// - Used as the arithmetic/flag stage of the datapath; one result per clock, fully pipelined.
// PARAMETERS
// - WIDTH  4  operand/result width in bits (>=2)
// PORTS
// - clk       in   1      single clock; all state updates on rising edge
// - rst_n     in   1      reset, synchronous, active-low
// - a         in   WIDTH  operand A (unsigned or two's complement)
// - b         in   WIDTH  operand B
// - select    in   2      opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
// - out       out  WIDTH  registered result
// - zero      out  1      result == 0
// - carry     out  1      ADD: carry-out; SUB: borrow (a<b unsigned); logic ops: 0
// - sign      out  1      result MSB
// - parity    out  1      XOR-reduction of result (1 = odd number of ones)
// - overflow  out  1      two's-complement overflow of ADD/SUB; logic ops: 0
// BEHAVIOUR
// - One clock; rst_n is synchronous and active-low: sampled only at rising clk.
// - Reset (rst_n=0 at edge): out=0, carry=0, sign=0, parity=0, overflow=0, zero=1.
// - Reset overrides any operation in the same cycle; no partial state survives.
// - Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
// - Throughput: new operation every cycle, no handshake, no stall.
// - Outputs hold their value between edges; all outputs change only on clk.
// - ADD: {c,r} = a + b in WIDTH+1 bits; out=r; carry=c.
// - ADD overflow = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
// - SUB: r = a - b mod 2^WIDTH; carry = (a < b) unsigned (borrow).
// - SUB overflow = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
// - AND/OR: out = a&b / a|b; carry=0; overflow=0.
// - zero, sign, parity always derive from the final registered out value
//   (post-saturation when ALU_SAT_EN is defined).
// - Wrap-around: without saturation, ADD/SUB results wrap modulo 2^WIDTH.
// - Operands and opcode are never X-checked; behaviour is defined for every code.
// CONFIGURATION
// - Macro ALU_SAT_EN (optional):
//   - defined: on ADD/SUB with overflow=1, out clamps to signed max (0111..1)
//     if the true result is positive, signed min (100..0) if negative.
//   - carry and overflow flags are still reported from the unsaturated operation.
//   - undefined: out wraps; no saturation logic is synthesised.
// TESTING (WIDTH=4, macro undefined unless noted; check one cycle after drive)
// - Reset: rst_n=0 for 1 edge, any a/b
//   -> out=0000, zero=1, carry=0, sign=0, parity=0, overflow=0.
// - ADD a=0111 b=0001 -> out=1000, overflow=1, sign=1, carry=0, zero=0, parity=1.
// - ADD a=1111 b=0001 -> out=0000, zero=1, carry=1, overflow=0, sign=0, parity=0.
// - SUB a=0011 b=0101 -> out=1110, carry=1, overflow=0, sign=1, parity=1.
// - SUB a=1000 b=0001 -> out=0111, overflow=1, carry=0, sign=0, parity=1.
// - AND a=1100 b=1010 -> out=1000, then OR same operands -> out=1110;
//   carry=0 and overflow=0 on both.
// - ALU_SAT_EN: ADD 0111+0001 -> out=0111, overflow=1.
// - ALU_SAT_EN: SUB 1000-0001 -> out=1000, overflow=1.
// - Back-to-back ops each cycle: results emerge in order, one per cycle.
// - rst_n low mid-stream clears outputs at that edge.

Source files
------------

// File: rtl/alu.sv
// alu: registered WIDTH-bit ADD/SUB/AND/OR ALU with zero/carry/sign/parity/overflow flags
// ports: clk, rst_n (sync, active-low), a, b, select (00 add, 01 sub, 10 and, 11 or),
//        out, zero, carry, sign, parity, overflow
// optional macro ALU_SAT_EN clamps overflowing ADD/SUB results to signed max/min
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] r, res;
  logic             c, v;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    r = select[1] ? (select[0] ? a | b : a & b) : (select[0] ? dif[M:0] : sum[M:0]);
    c = !select[1] && (select[0] ? dif[WIDTH] : sum[WIDTH]);
    // add overflows on like-signed operands, sub on unlike-signed; both when r's sign departs from a's
    v = !select[1] && ((a[M] ^ b[M]) == select[0]) && (r[M] != a[M]);
`ifdef ALU_SAT_EN
    // on overflow the true result has a's sign
    res = v ? (a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}}) : r;
`else
    res = r;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out      <= res;
      carry    <= c;
      overflow <= v;
    end
  end
  assign zero   = ~|out;
  assign sign   = out[M];
  assign parity = ^out;
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed check of alu against an integer-arithmetic reference model
module tb_alu;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [1:0] select;
  logic [3:0] out;
  logic       zero, carry, sign, parity, overflow;
  int         errors = 0;
  int         checks = 0;
  alu #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select),
    .out(out), .zero(zero), .carry(carry), .sign(sign), .parity(parity), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] x, input logic [3:0] y, input logic [1:0] s,
                     input string tag);
    int         sa, sb, t;
    logic [3:0] eo;
    logic       ec, ev;
    rst_n = r; a = x; b = y; select = s;
    sa = int'($signed(x));
    sb = int'($signed(y));
    ec = 1'b0; ev = 1'b0; t = 0;
    if (!r) eo = 4'd0;
    else if (s[1]) eo = s[0] ? (x | y) : (x & y);
    else begin
      t  = s[0] ? sa - sb : sa + sb;
      ec = s[0] ? (x < y) : ((int'(x) + int'(y)) > 15);
      ev = (t > 7) || (t < -8);
      eo = 4'(t);
`ifdef ALU_SAT_EN
      if (ev) eo = (t > 7) ? 4'b0111 : 4'b1000;
`endif
    end
    @(negedge clk);
    check({tag, ".out"}, 32'(out), 32'(eo));
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".ovf"}, 32'(overflow), 32'(ev));
    check({tag, ".zero"}, 32'(zero), 32'(eo == 4'd0));
    check({tag, ".sign"}, 32'(sign), 32'(eo[3]));
    check({tag, ".parity"}, 32'(parity), 32'($countones(eo) % 2));
  endtask
  initial begin
    logic [3:0] held;
    cyc(1'b0, 4'hA, 4'h5, 2'b00, "reset");
    cyc(1'b1, 4'b0111, 4'b0001, 2'b00, "add_ovf");
    cyc(1'b1, 4'b1111, 4'b0001, 2'b00, "add_carry");
    cyc(1'b1, 4'b0011, 4'b0101, 2'b01, "sub_borrow");
    cyc(1'b1, 4'b1000, 4'b0001, 2'b01, "sub_ovf");
    cyc(1'b1, 4'b1100, 4'b1010, 2'b10, "and");
    cyc(1'b1, 4'b1100, 4'b1010, 2'b11, "or");
    cyc(1'b1, 4'b0000, 4'b0000, 2'b01, "sub_zero");
    held = out;
    a = ~a; b = 4'hF; select = 2'b00;
    #2;
    check("hold", 32'(out), 32'(held));
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 19) != 0, 4'($urandom), 4'($urandom), 2'($urandom), "rand");
    cyc(1'b1, 4'b0110, 4'b0101, 2'b00, "pre_rst");
    cyc(1'b0, 4'b0110, 4'b0101, 2'b00, "mid_rst");
    cyc(1'b1, 4'b0110, 4'b0101, 2'b01, "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
